// File: rtl/recortador_pkg.sv
// Shared types and helpers for the multi-channel pad press detector.
package recortador_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } estado_t;

  localparam int DEBOUNCE_MIN = 1;

  function automatic int ancho_cnt(input int ciclos);
    return $clog2(ciclos + 1);
  endfunction

endpackage

// File: rtl/recortador_canal.sv
// One pad channel: synchroniser, debounce FSM and counter, press pulse.
// Optional release pulse on Suelta when RECORTADOR_SUELTA_EN is defined.
module recortador_canal
  import recortador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SYNC_STAGES     = 2
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic Respuesta,
  input  logic Habilitar,
  output logic PulsoSig,
  output logic RespuestaAclok,
  output logic Sostenida,
  output logic Suelta
);

  localparam int DEB = (DEBOUNCE_CYCLES < DEBOUNCE_MIN) ? DEBOUNCE_MIN : DEBOUNCE_CYCLES;
  localparam int CW  = ancho_cnt(DEB);
  localparam logic [CW-1:0] CNT_FIN = CW'(DEB);
  localparam logic [CW-1:0] CNT_UNO = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  estado_t                estado_q, estado_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pulso_d;
  logic                   pulso_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], Respuesta};
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef RECORTADOR_SUELTA_EN
  logic suelta_d;
  logic suelta_q;
`endif

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    pulso_d  = 1'b0;
`ifdef RECORTADOR_SUELTA_EN
    suelta_d = 1'b0;
`endif
    // Disable wins over any transition the FSM would otherwise take
    if (!Habilitar) begin
      estado_d = IDLE;
      cnt_d    = '0;
    end else begin
      case (estado_q)
        IDLE: begin
          if (s) begin
            estado_d = PRESS_CHK;
            cnt_d    = CNT_UNO;
          end
        end
        PRESS_CHK: begin
          if (!s) begin
            estado_d = IDLE;
            cnt_d    = '0;
          end else if (cnt_q == CNT_FIN) begin
            estado_d = HELD;
            cnt_d    = '0;
            pulso_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_UNO;
          end
        end
        HELD: begin
          if (!s) begin
            estado_d = RELEASE_CHK;
            cnt_d    = CNT_UNO;
          end
        end
        RELEASE_CHK: begin
          if (s) begin
            estado_d = HELD;
            cnt_d    = '0;
          end else if (cnt_q == CNT_FIN) begin
            estado_d = IDLE;
            cnt_d    = '0;
`ifdef RECORTADOR_SUELTA_EN
            suelta_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_UNO;
          end
        end
        default: begin
          estado_d = IDLE;
          cnt_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_q <= IDLE;
      cnt_q    <= '0;
      pulso_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      pulso_q  <= pulso_d;
    end
  end

`ifdef RECORTADOR_SUELTA_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) suelta_q <= 1'b0;
    else          suelta_q <= suelta_d;
  end
  assign Suelta = suelta_q;
`else
  assign Suelta = 1'b0;
`endif

  assign PulsoSig       = pulso_d;
  assign RespuestaAclok = pulso_q;
  assign Sostenida      = (estado_q == HELD) || (estado_q == RELEASE_CHK);

endmodule

// File: rtl/recortador_multicanal.sv
// Multi-channel debounced press detector for drum pads and buttons.
// Release pulses on Suelta are generated only when RECORTADOR_SUELTA_EN is defined.
module recortador_multicanal
  import recortador_pkg::*;
#(
  parameter int CANALES         = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [CANALES-1:0] Respuesta,
  input  logic [CANALES-1:0] Habilitar,
  output logic [CANALES-1:0] RespuestaAclok,
  output logic [CANALES-1:0] Sostenida,
  output logic               AlgunaRespuesta,
  output logic [CANALES-1:0] Suelta
);

  logic [CANALES-1:0] pulso_sig;

  for (genvar i = 0; i < CANALES; i++) begin : g_canal
    recortador_canal #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_canal (
      .Clock         (Clock),
      .Reset_n       (Reset_n),
      .Respuesta     (Respuesta[i]),
      .Habilitar     (Habilitar[i]),
      .PulsoSig      (pulso_sig[i]),
      .RespuestaAclok(RespuestaAclok[i]),
      .Sostenida     (Sostenida[i]),
      .Suelta        (Suelta[i])
    );
  end

  // Built from the next-cycle pulses so it lines up with RespuestaAclok
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) AlgunaRespuesta <= 1'b0;
    else          AlgunaRespuesta <= |pulso_sig;
  end

endmodule

// File: doc/recortador_multicanal.md
Name: recortador_multicanal

Overview:
- Parametrised multi-channel press detector for drum pads and buttons. Each asynchronous pad input is synchronised, then debounced.
- Each debounced press produces exactly one single-cycle pulse. A new pulse needs a debounced release first.
- Sits between the board pad inputs and the game scoring/note-hit logic.
- Successor to the single-channel, un-debounced, un-synchronised press-to-pulse cutter.

Parameters:
- CANALES, 4, number of independent pad channels (1..16).
- DEBOUNCE_CYCLES, 8, consecutive synchronised cycles at a level needed to accept a press or release (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- Respuesta  in  CANALES  raw pad levels, asynchronous to Clock; 1 = pressed.
- Habilitar  in  CANALES  per-channel enable; 0 forces the channel idle.
- RespuestaAclok  out  CANALES  one-cycle press pulse per channel, registered.
- Sostenida  out  CANALES  debounced level; 1 while the channel is HELD or RELEASE_CHK.
- AlgunaRespuesta  out  1  registered OR of all RespuestaAclok bits, same cycle as the pulses.
- Suelta  out  CANALES  one-cycle release pulse; see Optional Feature.

Behaviour:
- Reset (Reset_n=0, async): synchroniser flops 0, every channel state IDLE, counters 0, all outputs 0. Reset released mid-press: the channel starts from IDLE and must debounce again before any pulse.
- Synchroniser: s = Respuesta delayed through SYNC_STAGES flops.
- Per-channel FSM, counter width = clog2(DEBOUNCE_CYCLES+1):
  - IDLE: if s=1, go to PRESS_CHK with cnt=1.
  - PRESS_CHK: if s=0, go to IDLE with cnt=0. Else if cnt==DEBOUNCE_CYCLES, go to HELD, cnt=0, and set RespuestaAclok bit to 1 for one cycle. Else cnt+1.
  - HELD: if s=0, go to RELEASE_CHK with cnt=1.
  - RELEASE_CHK: if s=1, go to HELD with cnt=0 (no new pulse). Else if cnt==DEBOUNCE_CYCLES, go to IDLE, cnt=0, and pulse Suelta (feature only). Else cnt+1.
- Latency: raw rise captured at edge k, held high, gives RespuestaAclok=1 during the cycle after edge k+SYNC_STAGES+DEBOUNCE_CYCLES. Exactly one cycle.
- Holding the pad indefinitely gives no further pulses. Bounces shorter than DEBOUNCE_CYCLES never change the debounced level.
- Habilitar=0: channel goes synchronously to IDLE, cnt=0, and that channel's outputs go to 0 at the next edge, overriding any transition in that cycle. The synchroniser keeps running. Re-enabling while the pad is held gives a fresh pulse after debounce.
- Simultaneous presses on several channels: each channel pulses independently in the same cycle. AlgunaRespuesta=1 once.
- The counter never wraps; it saturates at the compare point by construction.

Optional Feature:
- Macro RECORTADOR_SUELTA_EN.
- Defined: Suelta pulses for one cycle on the RELEASE_CHK->IDLE transition. Release latency is the same as press latency.
- Undefined: no RELEASE_CHK->IDLE pulse logic is generated, Suelta is tied to 0, and the FSM is unchanged.

Decomposition:
- Package recortador_pkg:
  - state enum {IDLE, PRESS_CHK, HELD, RELEASE_CHK}, 2 bits.
  - function for counter width.
  - DEBOUNCE_CYCLES lower-bound constant.
- Sub-module recortador_canal: synchroniser + FSM + counter for one channel.
- Top instantiates CANALES copies in a generate loop and registers AlgunaRespuesta.

Test Plan (CANALES=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2 unless stated):
- Clean press: Respuesta[0] goes 0->1 before edge 10 and is held 50 cycles. RespuestaAclok[0]=1 only in the cycle after edge 16; AlgunaRespuesta is identical; Sostenida[0] is 1 from then on.
- Bounce: Respuesta[1] is high 3 cycles, low 2, high 3. No pulse and Sostenida[1] stays 0. Then held 10 cycles: exactly one pulse.
- Release glitch: channel 2 HELD, 2-cycle low glitch, pad still held. No new pulse and Sostenida stays 1. Full release then re-press: a second pulse.
- Simultaneous: channels 0 and 3 rise on the same edge. Both pulse in the same cycle and AlgunaRespuesta is high for one cycle.
- Enable/reset: Habilitar[1]=0 mid-PRESS_CHK gives no pulse; re-enable with the pad held gives a pulse 4 cycles after the enable edge. Reset_n asserted async mid-HELD clears all outputs immediately.
- RECORTADOR_SUELTA_EN defined: release held low gives Suelta=1 one cycle after edge release+6. Macro undefined: Suelta stays 0 throughout.
